// File: rtl/mm_job_scheduler_pkg.sv
// Shared types and default sizing for the matrix-multiply job scheduler.
package mm_job_scheduler_pkg;

    localparam int DEF_ELEMENT_SIZE   = 8;
    localparam int DEF_MAX_SIZE_A     = 32;
    localparam int DEF_MAX_SIZE_B     = 32;
    localparam int DEF_NUM_LANES      = 4;
    localparam int DEF_TIMEOUT_CYCLES = 255;
    localparam int DEF_A_VEC_W        = DEF_MAX_SIZE_A * DEF_ELEMENT_SIZE;
    localparam int DEF_B_VEC_W        = DEF_MAX_SIZE_B * DEF_ELEMENT_SIZE;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } sched_state_t;

    // Index width that stays legal for a single-entry range.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mm_job_scheduler_rr_arbiter.sv
// Round-robin pick of the first free lane at or after the pointer.
module rr_arbiter
    import mm_job_scheduler_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_w(N)
)(
    input  logic [N-1:0]  i_free,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any_free
);

    int w_sum;

    always_comb begin
        o_grant    = '0;
        o_idx      = '0;
        o_any_free = 1'b0;
        w_sum      = 0;
        for (int i = 0; i < N; i++) begin
            w_sum = int'(i_ptr) + i;
            if (w_sum >= N) w_sum = w_sum - N;
            if (!o_any_free && ((i_free >> w_sum) & N'(1)) != '0) begin
                o_any_free = 1'b1;
                o_idx      = IW'(w_sum);
                o_grant    = N'(1) << w_sum;
            end
        end
    end

endmodule

// File: rtl/mm_job_scheduler.sv
// Walks every (A row, B col) pair, fetches operands and dispatches them round-robin to lanes.
// Optional WAIT watchdog enabled by SCHED_TIMEOUT_EN.
//   state | meaning
//   IDLE  | waiting for start_in
//   ISSUE | waiting for a free lane, then requests operands for (r,c)
//   WAIT  | waiting for the tagged loader response
//   DRAIN | all pairs dispatched, waiting for lanes to finish
//   FIN   | one-cycle done pulse
module mm_job_scheduler
    import mm_job_scheduler_pkg::*;
#(
    parameter  int MAX_ELEMENT_SIZE = DEF_ELEMENT_SIZE,
    parameter  int MAX_SIZE_A       = DEF_MAX_SIZE_A,
    parameter  int MAX_SIZE_B       = DEF_MAX_SIZE_B,
    parameter  int NUM_LANES        = DEF_NUM_LANES,
`ifdef SCHED_TIMEOUT_EN
    parameter  int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES,
`endif
    localparam int RW  = $clog2(MAX_SIZE_A),
    localparam int CW  = $clog2(MAX_SIZE_B),
    localparam int AVW = MAX_SIZE_A * MAX_ELEMENT_SIZE,
    localparam int BVW = MAX_SIZE_B * MAX_ELEMENT_SIZE
)(
    input  logic                 clk_in,
    input  logic                 rst_in_n,
    input  logic                 start_in,
    input  logic [RW:0]          rows_in,
    input  logic [CW:0]          cols_in,
    output logic                 valid_request_out,
    output logic [RW-1:0]        row_req_out,
    output logic [CW-1:0]        col_req_out,
    input  logic                 val_rows_in,
    input  logic [RW-1:0]        row_in,
    input  logic [CW-1:0]        col_in,
    input  logic [AVW-1:0]       a_row_in,
    input  logic [BVW-1:0]       b_col_in,
    output logic [NUM_LANES-1:0] lane_start_out,
    output logic [AVW-1:0]       lane_a_out,
    output logic [BVW-1:0]       lane_b_out,
    output logic [RW-1:0]        lane_row_out,
    output logic [CW-1:0]        lane_col_out,
    input  logic [NUM_LANES-1:0] lane_done_in,
    output logic                 busy_out,
    output logic                 done_out,
    output logic                 err_out
);

    localparam int LW = idx_w(NUM_LANES);

    sched_state_t         r_state;
    logic [RW:0]          r_rows;
    logic [CW:0]          r_cols;
    logic [RW-1:0]        r_r;
    logic [CW-1:0]        r_c;
    logic [NUM_LANES-1:0] r_busy;
    logic [NUM_LANES-1:0] r_grant;
    logic [LW-1:0]        r_ptr;
    logic [LW-1:0]        r_lane;
    logic                 r_valid_req;
    logic [RW-1:0]        r_row_req;
    logic [CW-1:0]        r_col_req;
    logic [NUM_LANES-1:0] r_lane_start;
    logic [AVW-1:0]       r_lane_a;
    logic [BVW-1:0]       r_lane_b;
    logic [RW-1:0]        r_lane_row;
    logic [CW-1:0]        r_lane_col;
    logic                 r_busy_o;
    logic                 r_done;
    logic                 r_err;
`ifdef SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]        r_wait_cnt;
`endif

    logic [NUM_LANES-1:0] w_free;
    logic [NUM_LANES-1:0] w_grant;
    logic [LW-1:0]        w_idx;
    logic                 w_any_free;
    logic                 w_match;
    logic                 w_dispatch;
    logic [NUM_LANES-1:0] w_set;
    logic                 w_last_c;
    logic                 w_last_r;
    logic [LW-1:0]        w_next_ptr;

    assign w_free     = ~r_busy;
    assign w_match    = val_rows_in && (row_in == r_r) && (col_in == r_c);
    assign w_dispatch = (r_state == ST_WAIT) && w_match;
    assign w_set      = w_dispatch ? r_grant : '0;
    assign w_last_c   = ({1'b0, r_c} == r_cols - (CW+1)'(1));
    assign w_last_r   = ({1'b0, r_r} == r_rows - (RW+1)'(1));
    assign w_next_ptr = (r_lane == LW'(NUM_LANES - 1)) ? '0 : r_lane + LW'(1);

    rr_arbiter #(.N(NUM_LANES)) u_arb (
        .i_free     (w_free),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_idx      (w_idx),
        .o_any_free (w_any_free)
    );

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_state      <= ST_IDLE;
            r_rows       <= '0;
            r_cols       <= '0;
            r_r          <= '0;
            r_c          <= '0;
            r_busy       <= '0;
            r_grant      <= '0;
            r_ptr        <= '0;
            r_lane       <= '0;
            r_valid_req  <= 1'b0;
            r_row_req    <= '0;
            r_col_req    <= '0;
            r_lane_start <= '0;
            r_lane_a     <= '0;
            r_lane_b     <= '0;
            r_lane_row   <= '0;
            r_lane_col   <= '0;
            r_busy_o     <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            r_wait_cnt   <= '0;
`endif
        end else begin
            r_valid_req  <= 1'b0;
            r_done       <= 1'b0;
            r_lane_start <= w_set;
            // A start on a lane outranks its done pulse in the same cycle.
            r_busy       <= (r_busy & ~lane_done_in) | w_set;
`ifdef SCHED_TIMEOUT_EN
            r_wait_cnt   <= '0;
`endif
            if (w_dispatch) begin
                r_lane_a   <= a_row_in;
                r_lane_b   <= b_col_in;
                r_lane_row <= r_r;
                r_lane_col <= r_c;
                r_ptr      <= w_next_ptr;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start_in) begin
                        r_rows   <= rows_in;
                        r_cols   <= cols_in;
                        r_r      <= '0;
                        r_c      <= '0;
                        r_busy_o <= 1'b1;
                        r_state  <= (rows_in == '0 || cols_in == '0) ? ST_FIN : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_any_free) begin
                        r_valid_req <= 1'b1;
                        r_row_req   <= r_r;
                        r_col_req   <= r_c;
                        r_grant     <= w_grant;
                        r_lane      <= w_idx;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_match) begin
                        if (w_last_c) begin
                            r_c <= '0;
                            r_r <= r_r + RW'(1);
                        end else begin
                            r_c <= r_c + CW'(1);
                        end
                        r_state <= (w_last_c && w_last_r) ? ST_DRAIN : ST_ISSUE;
                    end else begin
                        if (val_rows_in) r_err <= 1'b1;
`ifdef SCHED_TIMEOUT_EN
                        // Expiry re-enters ISSUE, which re-requests the same pair.
                        if (r_wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                            r_err   <= 1'b1;
                            r_state <= ST_ISSUE;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + TW'(1);
                        end
`endif
                    end
                end
                ST_DRAIN: begin
                    if (r_busy == '0) r_state <= ST_FIN;
                end
                ST_FIN: begin
                    r_done   <= 1'b1;
                    r_busy_o <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign valid_request_out = r_valid_req;
    assign row_req_out       = r_row_req;
    assign col_req_out       = r_col_req;
    assign lane_start_out    = r_lane_start;
    assign lane_a_out        = r_lane_a;
    assign lane_b_out        = r_lane_b;
    assign lane_row_out      = r_lane_row;
    assign lane_col_out      = r_lane_col;
    assign busy_out          = r_busy_o;
    assign done_out          = r_done;
    assign err_out           = r_err;

endmodule

// File: tb/tb_mm_job_scheduler.sv
// Directed bench for mm_job_scheduler with loader/lane models and request/dispatch scoreboards.
module tb_mm_job_scheduler;

    localparam int NL  = 2;
    localparam int RW  = 5;
    localparam int CW  = 5;
    localparam int AVW = 256;
    localparam int BVW = 256;
    localparam int TO  = 255;

    typedef struct packed {
        logic [RW-1:0] r;
        logic [CW-1:0] c;
    } pair_t;
    typedef struct {
        int    lane;
        pair_t p;
    } disp_t;
    typedef struct {
        int    due;
        pair_t p;
    } ld_t;

    logic           clk_in   = 1'b0;
    logic           rst_in_n = 1'b1;
    logic           start_in = 1'b0;
    logic [RW:0]    rows_in  = '0;
    logic [CW:0]    cols_in  = '0;
    logic           valid_request_out;
    logic [RW-1:0]  row_req_out;
    logic [CW-1:0]  col_req_out;
    logic           val_rows_in;
    logic [RW-1:0]  row_in;
    logic [CW-1:0]  col_in;
    logic [AVW-1:0] a_row_in;
    logic [BVW-1:0] b_col_in;
    logic [NL-1:0]  lane_start_out;
    logic [AVW-1:0] lane_a_out;
    logic [BVW-1:0] lane_b_out;
    logic [RW-1:0]  lane_row_out;
    logic [CW-1:0]  lane_col_out;
    logic [NL-1:0]  lane_done_in;
    logic           busy_out;
    logic           done_out;
    logic           err_out;

    int n_vec = 0, n_err = 0;
    int cyc = 0;
    int n_req = 0, n_disp = 0, n_done = 0;
    int done_cyc = 0, last_done_cyc = 0, last_good_cyc = -10;
    int last_req_cyc = 0, prev_req_cyc = 0;
    int start_cyc = 0;
    bit ld_en = 1'b1, lane_en = 1'b1;
    int ld_bad_count = 0, ld_bad_used = 0;
    int lane_due [NL] = '{default: -1};

    pair_t q_req[$];
    disp_t q_disp[$];
    ld_t   ld_q[$];
    ld_t   it;
    pair_t exp_p;
    disp_t exp_d;

    mm_job_scheduler #(.NUM_LANES(NL)) dut (
        .clk_in            (clk_in),
        .rst_in_n          (rst_in_n),
        .start_in          (start_in),
        .rows_in           (rows_in),
        .cols_in           (cols_in),
        .valid_request_out (valid_request_out),
        .row_req_out       (row_req_out),
        .col_req_out       (col_req_out),
        .val_rows_in       (val_rows_in),
        .row_in            (row_in),
        .col_in            (col_in),
        .a_row_in          (a_row_in),
        .b_col_in          (b_col_in),
        .lane_start_out    (lane_start_out),
        .lane_a_out        (lane_a_out),
        .lane_b_out        (lane_b_out),
        .lane_row_out      (lane_row_out),
        .lane_col_out      (lane_col_out),
        .lane_done_in      (lane_done_in),
        .busy_out          (busy_out),
        .done_out          (done_out),
        .err_out           (err_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [AVW-1:0] a_vec(input logic [RW-1:0] r);
        return {8{24'hA5A5A5, 3'b000, r}};
    endfunction

    function automatic logic [BVW-1:0] b_vec(input logic [CW-1:0] c);
        return {8{24'h3C3C3C, 3'b000, c}};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_valid_req"},  valid_request_out, 0);
        chk({pfx, "_row_req"},    row_req_out, 0);
        chk({pfx, "_col_req"},    col_req_out, 0);
        chk({pfx, "_lane_start"}, lane_start_out, 0);
        chk({pfx, "_lane_a"},     lane_a_out, 0);
        chk({pfx, "_lane_b"},     lane_b_out, 0);
        chk({pfx, "_lane_row"},   lane_row_out, 0);
        chk({pfx, "_lane_col"},   lane_col_out, 0);
        chk({pfx, "_busy"},       busy_out, 0);
        chk({pfx, "_done"},       done_out, 0);
        chk({pfx, "_err"},        err_out, 0);
    endtask

    task automatic push_job(input int rows, input int cols, input int first, input int limit);
        int    k = 0;
        pair_t p;
        disp_t dd;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                if (k < limit) begin
                    p.r = RW'(r);
                    p.c = CW'(c);
                    dd.lane = (first + k) % NL;
                    dd.p    = p;
                    q_req.push_back(p);
                    q_disp.push_back(dd);
                end
                k++;
            end
        end
    endtask

    task automatic start_job(input int rows, input int cols);
        tick();
        rows_in   = (RW+1)'(rows);
        cols_in   = (CW+1)'(cols);
        start_in  = 1'b1;
        start_cyc = cyc;
        tick();
        start_in  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0 = n_done;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (n_done != d0) break;
        end
        chk(tag, n_done - d0, 1);
    endtask

    task automatic wait_req(input string tag, input int budget);
        int r0 = n_req;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (n_req != r0) break;
        end
        chk(tag, n_req - r0, 1);
    endtask

    // Loader model: answers each recorded request 3 cycles later; can corrupt a col tag once.
    initial begin
        val_rows_in = 1'b0;
        row_in      = '0;
        col_in      = '0;
        a_row_in    = '0;
        b_col_in    = '0;
        forever begin
            @(negedge clk_in);
            val_rows_in = 1'b0;
            if (!rst_in_n) begin
                ld_q.delete();
            end else begin
                if (valid_request_out && ld_en) begin
                    it.due = cyc + 3;
                    it.p   = {row_req_out, col_req_out};
                    ld_q.push_back(it);
                end
                if (ld_q.size() > 0 && ld_q[0].due <= cyc) begin
                    it          = ld_q.pop_front();
                    val_rows_in = 1'b1;
                    row_in      = it.p.r;
                    col_in      = it.p.c;
                    a_row_in    = a_vec(it.p.r);
                    b_col_in    = b_vec(it.p.c);
                    if (ld_bad_used < ld_bad_count) begin
                        ld_bad_used++;
                        col_in = CW'(7);
                        it.due = cyc + 3;
                        ld_q.push_front(it);
                    end else begin
                        last_good_cyc = cyc;
                    end
                end
            end
        end
    end

    // Lane model: each started lane pulses done 5 cycles later when enabled.
    initial begin
        lane_done_in = '0;
        forever begin
            @(negedge clk_in);
            for (int k = 0; k < NL; k++) begin
                lane_done_in[k] = (lane_due[k] == cyc);
                if (lane_done_in[k]) last_done_cyc = cyc;
                if (lane_start_out[k] && lane_en) lane_due[k] = cyc + 5;
            end
            if (!rst_in_n) begin
                lane_done_in = '0;
                lane_due     = '{default: -1};
            end
        end
    end

    // Monitor: pops scoreboards as the DUT emits requests and dispatches.
    always @(negedge clk_in) begin
        if (rst_in_n) begin
            if (valid_request_out) begin
                n_req++;
                prev_req_cyc = last_req_cyc;
                last_req_cyc = cyc;
                chk("req_expected", q_req.size() > 0, 1);
                if (q_req.size() > 0) begin
                    exp_p = q_req.pop_front();
                    chk("req_addr", {row_req_out, col_req_out}, exp_p);
                end
            end
            if (lane_start_out != '0) begin
                n_disp++;
                chk("disp_expected", q_disp.size() > 0, 1);
                if (q_disp.size() > 0) begin
                    exp_d = q_disp.pop_front();
                    chk("disp_lane",    lane_start_out, NL'(1) << exp_d.lane);
                    chk("disp_row",     lane_row_out, exp_d.p.r);
                    chk("disp_col",     lane_col_out, exp_d.p.c);
                    chk("disp_a",       lane_a_out, a_vec(exp_d.p.r));
                    chk("disp_b",       lane_b_out, b_vec(exp_d.p.c));
                    chk("disp_latency", cyc, last_good_cyc + 1);
                end
            end
            if (done_out) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired n_vec=%0d n_err=%0d", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0, p0;
        #2 rst_in_n = 1'b0;
        repeat (3) tick();
        chk_zero("reset");
        rst_in_n = 1'b1;
        tick();

        // 2x2 job, lanes alternate 0,1,0,1
        push_job(2, 2, 0, 4);
        d0 = n_done;
        start_job(2, 2);
        wait_done("t1_done", 200);
        chk("t1_done_after_lane", done_cyc - last_done_cyc, 3);
        repeat (5) tick();
        chk("t1_single_done", n_done - d0, 1);
        chk("t1_req_drained", q_req.size(), 0);
        chk("t1_disp_drained", q_disp.size(), 0);
        chk("t1_busy_idle", busy_out, 0);
        chk("t1_err", err_out, 0);

        // zero-row job
        r0 = n_req;
        start_job(0, 5);
        wait_done("t2_done", 20);
        chk("t2_done_latency", done_cyc - start_cyc, 2);
        chk("t2_no_request", n_req - r0, 0);
        chk("t2_err", err_out, 0);

        // corrupted tag then correct response; RR pointer is at lane 0
        ld_bad_count++;
        push_job(1, 1, 0, 1);
        p0 = n_disp;
        start_job(1, 1);
        wait_done("t4_done", 100);
        chk("t4_err_sticky", err_out, 1);
        chk("t4_one_dispatch", n_disp - p0, 1);

        // lanes never finish: 2 dispatches (lanes 1 then 0), then stuck in ISSUE
        lane_en = 1'b0;
        push_job(3, 3, 1, 2);
        p0 = n_disp;
        d0 = n_done;
        start_job(3, 3);
        repeat (60) tick();
        chk("t3_dispatch_count", n_disp - p0, 2);
        chk("t3_busy_held", busy_out, 1);
        chk("t3_no_done", n_done - d0, 0);
        chk("t3_no_extra_req", q_req.size(), 0);

        rst_in_n = 1'b0;
        tick();
        rst_in_n = 1'b1;
        lane_en  = 1'b1;
        tick();

        // reset in WAIT of a 4x4 job, then a clean rerun
        push_job(4, 4, 0, 1);
        start_job(4, 4);
        wait_req("t5_first_req", 10);
        rst_in_n = 1'b0;
        #1;
        chk_zero("t5_midrst");
        q_disp.delete();
        tick();
        rst_in_n = 1'b1;
        tick();
        push_job(4, 4, 0, 16);
        start_job(4, 4);
        wait_done("t5_done", 400);
        chk("t5_req_drained", q_req.size(), 0);
        chk("t5_disp_drained", q_disp.size(), 0);
        chk("t5_err", err_out, 0);

`ifdef SCHED_TIMEOUT_EN
        // silent loader: same pair re-requested after each timeout
        rst_in_n = 1'b0;
        tick();
        rst_in_n = 1'b1;
        tick();
        ld_en = 1'b0;
        push_job(1, 1, 0, 1);
        exp_p = '0;
        q_req.push_back(exp_p);
        q_req.push_back(exp_p);
        start_job(1, 1);
        wait_req("t6_req1", 10);
        wait_req("t6_req2", TO + 20);
        chk("t6_period", last_req_cyc - prev_req_cyc, TO + 1);
        chk("t6_err", err_out, 1);
        ld_en = 1'b1;
        wait_done("t6_done", 2 * TO + 40);
        chk("t6_req_drained", q_req.size(), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
